approx_wallace_product_accumulator: RTL and testbench

Sequential accumulation stage directly downstream of the approximate 8-bit Wallace-tree reduction layers. It consumes the 16-bit approximate product bits produced by the final reduction layer, one product per cycle, through a valid/ready handshake. It sums `N_TERMS` products into a saturating accumulator, then presents the result on an output valid/ready handshake. It is the "accumulation" half of the approximate multiply-accumulate datapath.

---
 rtl/approx_wallace_product_accumulator_if.sv | 42 ++++
 rtl/approx_wallace_product_accumulator.sv | 123 ++++++++++++
 tb/tb_approx_wallace_product_accumulator.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_wallace_product_accumulator_if.sv
// Handshake bundle between the approximate Wallace-tree product stream,
// the product accumulator, and the downstream result consumer.
interface approx_wallace_product_accumulator_if #(
    parameter int ACC_W = 20,
    parameter int CNT_W = 5
);
    logic [15:0]      prod_i;
    logic             prod_valid_i;
    logic             prod_ready_o;
    logic             clear_i;
    logic [ACC_W-1:0] acc_o;
    logic             acc_valid_o;
    logic             acc_ready_i;
    logic             sat_o;
    logic [CNT_W-1:0] count_o;

    // Accumulator side
    modport slave (
        input  prod_i,
        input  prod_valid_i,
        output prod_ready_o,
        input  clear_i,
        output acc_o,
        output acc_valid_o,
        input  acc_ready_i,
        output sat_o,
        output count_o
    );

    // Producer / consumer side
    modport master (
        output prod_i,
        output prod_valid_i,
        input  prod_ready_o,
        output clear_i,
        input  acc_o,
        input  acc_valid_o,
        output acc_ready_i,
        input  sat_o,
        input  count_o
    );
endinterface

// File: rtl/approx_wallace_product_accumulator.sv
// Saturating accumulator for approximate 16-bit Wallace-tree products.
// Sums N_TERMS products (one per cycle) through an input register stage,
// then holds the result on a valid/ready output until it is taken.
module approx_wallace_product_accumulator #(
    parameter int ACC_W   = 20,
    parameter int N_TERMS = 16,
    parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
    input logic clk,
    input logic rst,
    approx_wallace_product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      prod_q;
    logic             pv_q;
    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic [CNT_W-1:0] count_q;
    logic             valid_q;

    logic             ready;
    logic             accept;
    logic             last_beat;
    logic [ACC_W:0]   sum;

    // Ready depends only on state and clear so it never waits on valid
    always_comb begin
        ready     = (state == ACCUM) && !bus.clear_i;
        accept    = bus.prod_valid_i && ready;
        last_beat = (count_q == CNT_W'(N_TERMS - 1));
    end

    // One extra bit above the accumulator catches the overflow carry
    always_comb begin
        sum = {{(ACC_W - 15){1'b0}}, prod_q} + {1'b0, acc_q};
    end

    // Input register stage: capture an accepted product for next-cycle add
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
        end else if (bus.clear_i) begin
            pv_q   <= 1'b0;
        end else begin
            pv_q <= accept;
            if (accept) begin
                prod_q <= bus.prod_i;
            end
        end
    end

    // Control FSM with accumulator, term counter and sticky saturation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (bus.clear_i) begin
            state   <= ACCUM;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                count_q <= count_q + CNT_W'(1);
            end

            // Once saturated the sum is pinned at all-ones until restart
            if (pv_q) begin
                if (sum[ACC_W] || sat_q) begin
                    acc_q <= '1;
                    sat_q <= 1'b1;
                end else begin
                    acc_q <= sum[ACC_W-1:0];
                end
            end

            unique case (state)
                ACCUM: begin
                    if (accept && last_beat) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state   <= DONE;
                    valid_q <= 1'b1;
                end
                DONE: begin
                    // pv_q is always low here, so the restart cannot race an add
                    if (bus.acc_ready_i) begin
                        state   <= ACCUM;
                        valid_q <= 1'b0;
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        count_q <= '0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    // Drive the interface outputs from registered state
    always_comb begin
        bus.prod_ready_o = ready;
        bus.acc_o        = acc_q;
        bus.acc_valid_o  = valid_q;
        bus.sat_o        = sat_q;
        bus.count_o      = count_q;
    end
endmodule

// File: tb/tb_approx_wallace_product_accumulator.sv
// Bench for approx_wallace_product_accumulator: two instances (ACC_W=20 and
// ACC_W=17, both N_TERMS=4) share one stimulus stream so the same sequence
// exercises both the non-saturating and saturating widths.
module tb_approx_wallace_product_accumulator;
    localparam longint MAX_A = (longint'(1) << 20) - 1;
    localparam longint MAX_B = (longint'(1) << 17) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prod;
    logic        prod_valid;
    logic        clear;
    logic        acc_ready;

    int checks   = 0;
    int failures = 0;

    logic [15:0] beats [4];
    longint      total;

    always #5 clk = ~clk;

    approx_wallace_product_accumulator_if #(.ACC_W(20), .CNT_W(3)) ifa ();
    approx_wallace_product_accumulator_if #(.ACC_W(17), .CNT_W(3)) ifb ();

    assign ifa.prod_i       = prod;
    assign ifa.prod_valid_i = prod_valid;
    assign ifa.clear_i      = clear;
    assign ifa.acc_ready_i  = acc_ready;
    assign ifb.prod_i       = prod;
    assign ifb.prod_valid_i = prod_valid;
    assign ifb.clear_i      = clear;
    assign ifb.acc_ready_i  = acc_ready;

    approx_wallace_product_accumulator #(.ACC_W(20), .N_TERMS(4), .CNT_W(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    approx_wallace_product_accumulator #(.ACC_W(17), .N_TERMS(4), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Ideal sum clipped to the largest value a w-bit accumulator can hold
    function automatic longint clip(input longint s, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (s > mx) ? mx : s;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Push beats[0..3] with random bubbles; returns at the negedge after the
    // last accept (accumulator in its drain cycle). Sum goes to total.
    task automatic feed_beats(input int bmin, input int bmax);
        longint partial;
        int     nb;
        partial = 0;
        for (int i = 0; i < 4; i++) begin
            nb = int'($urandom_range(bmax, bmin));
            for (int b = 0; b < nb; b++) begin
                prod_valid = 1'b0;
                prod = 16'($urandom);
                step();
                checks++;
                if (ifa.prod_ready_o !== 1'b1 || ifa.count_o !== 3'(i) || ifb.count_o !== 3'(i))
                    begin failures++; $display("FAIL bubble_ready_count: ready=%b count_a=%0d count_b=%0d want ready=1 count=%0d", ifa.prod_ready_o, ifa.count_o, ifb.count_o, i); end
                checks++;
                if (ifa.acc_o !== 20'(clip(partial, 20)) || ifb.acc_o !== 17'(clip(partial, 17)))
                    begin failures++; $display("FAIL bubble_acc: acc_a=%0h acc_b=%0h want %0h/%0h", ifa.acc_o, ifb.acc_o, clip(partial, 20), clip(partial, 17)); end
            end
            prod = beats[i];
            prod_valid = 1'b1;
            #1;
            checks++;
            if (ifa.prod_ready_o !== 1'b1 || ifb.prod_ready_o !== 1'b1)
                begin failures++; $display("FAIL accum_ready: ready_a=%b ready_b=%b want 1", ifa.prod_ready_o, ifb.prod_ready_o); end
            step();
            prod_valid = 1'b0;
            checks++;
            if (ifa.count_o !== 3'(i + 1) || ifb.count_o !== 3'(i + 1))
                begin failures++; $display("FAIL accept_count: count_a=%0d count_b=%0d want %0d", ifa.count_o, ifb.count_o, i + 1); end
            // Only beats accepted at earlier edges are visible in acc yet
            checks++;
            if (ifa.acc_o !== 20'(clip(partial, 20)) || ifb.acc_o !== 17'(clip(partial, 17)))
                begin failures++; $display("FAIL accept_acc: acc_a=%0h acc_b=%0h want %0h/%0h", ifa.acc_o, ifb.acc_o, clip(partial, 20), clip(partial, 17)); end
            checks++;
            if (ifa.sat_o !== (partial > MAX_A) || ifb.sat_o !== (partial > MAX_B))
                begin failures++; $display("FAIL accept_sat: sat_a=%b sat_b=%b want %b/%b", ifa.sat_o, ifb.sat_o, partial > MAX_A, partial > MAX_B); end
            partial += longint'(beats[i]);
        end
        total = partial;
        checks++;
        if (ifa.acc_valid_o !== 1'b0 || ifa.prod_ready_o !== 1'b0 || ifb.acc_valid_o !== 1'b0)
            begin failures++; $display("FAIL drain_state: valid_a=%b valid_b=%b ready=%b want 0/0/0", ifa.acc_valid_o, ifb.acc_valid_o, ifa.prod_ready_o); end
    endtask

    // From the drain cycle: check the result, hold it for `hold` cycles of
    // backpressure, then release it (optionally together with clear).
    task automatic finish_result(input int hold, input bit junk, input bit with_clear);
        prod_valid = junk;
        prod = 16'($urandom);
        step();
        checks++;
        if (ifa.acc_valid_o !== 1'b1 || ifb.acc_valid_o !== 1'b1 || ifa.prod_ready_o !== 1'b0)
            begin failures++; $display("FAIL done_valid: valid_a=%b valid_b=%b ready=%b want 1/1/0", ifa.acc_valid_o, ifb.acc_valid_o, ifa.prod_ready_o); end
        checks++;
        if (ifa.acc_o !== 20'(clip(total, 20)) || ifb.acc_o !== 17'(clip(total, 17)))
            begin failures++; $display("FAIL done_acc: acc_a=%0h acc_b=%0h want %0h/%0h", ifa.acc_o, ifb.acc_o, clip(total, 20), clip(total, 17)); end
        checks++;
        if (ifa.sat_o !== (total > MAX_A) || ifb.sat_o !== (total > MAX_B) || ifa.count_o !== 3'd4)
            begin failures++; $display("FAIL done_sat_count: sat_a=%b sat_b=%b count=%0d want %b/%b/4", ifa.sat_o, ifb.sat_o, ifa.count_o, total > MAX_A, total > MAX_B); end
        for (int h = 0; h < hold; h++) begin
            acc_ready = 1'b0;
            prod = 16'($urandom);
            step();
            checks++;
            if (ifa.acc_valid_o !== 1'b1 || ifa.prod_ready_o !== 1'b0 || ifa.count_o !== 3'd4 ||
                ifa.acc_o !== 20'(clip(total, 20)) || ifb.acc_o !== 17'(clip(total, 17)))
                begin failures++; $display("FAIL hold_stable: valid=%b ready=%b count=%0d acc_a=%0h acc_b=%0h want 1/0/4/%0h/%0h", ifa.acc_valid_o, ifa.prod_ready_o, ifa.count_o, ifa.acc_o, ifb.acc_o, clip(total, 20), clip(total, 17)); end
        end
        acc_ready = 1'b1;
        clear = with_clear;
        step();
        acc_ready = 1'b0;
        clear = 1'b0;
        prod_valid = 1'b0;
        #1;
        checks++;
        if (ifa.prod_ready_o !== 1'b1 || ifa.acc_valid_o !== 1'b0 || ifb.acc_valid_o !== 1'b0)
            begin failures++; $display("FAIL release_state: ready=%b valid_a=%b valid_b=%b want 1/0/0", ifa.prod_ready_o, ifa.acc_valid_o, ifb.acc_valid_o); end
        checks++;
        if (ifa.acc_o !== 20'd0 || ifb.acc_o !== 17'd0 || ifa.count_o !== 3'd0 || ifb.sat_o !== 1'b0)
            begin failures++; $display("FAIL release_clear: acc_a=%0h acc_b=%0h count=%0d sat_b=%b want 0/0/0/0", ifa.acc_o, ifb.acc_o, ifa.count_o, ifb.sat_o); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        prod = '0;
        prod_valid = 1'b0;
        clear = 1'b0;
        acc_ready = 1'b0;
        step();
        step();
        checks++;
        if (ifa.acc_o !== 20'd0 || ifb.acc_o !== 17'd0 || ifa.acc_valid_o !== 1'b0 ||
            ifa.sat_o !== 1'b0 || ifa.count_o !== 3'd0 || ifa.prod_ready_o !== 1'b1)
            begin failures++; $display("FAIL reset_values: acc=%0h valid=%b sat=%b count=%0d ready=%b want 0/0/0/0/1", ifa.acc_o, ifa.acc_valid_o, ifa.sat_o, ifa.count_o, ifa.prod_ready_o); end
        clear = 1'b1;
        #1;
        checks++;
        if (ifa.prod_ready_o !== 1'b0)
            begin failures++; $display("FAIL ready_vs_clear: ready=%b want 0", ifa.prod_ready_o); end
        clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_sum();
        beats[0] = 16'd1; beats[1] = 16'd2; beats[2] = 16'd3; beats[3] = 16'd4;
        feed_beats(0, 0);
        finish_result(0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) beats[i] = 16'hFFFF;
        feed_beats(2, 2);
        finish_result(5, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) beats[i] = 16'hFFFF;
        feed_beats(0, 0);
        finish_result(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) beats[i] = 16'd1;
        feed_beats(0, 0);
        finish_result(0, 1'b0, 1'b0);
    endtask

    task automatic test_clear_mid();
        prod = 16'd100;
        prod_valid = 1'b1;
        step();
        step();
        clear = 1'b1;
        #1;
        checks++;
        if (ifa.prod_ready_o !== 1'b0 || ifa.count_o !== 3'd2)
            begin failures++; $display("FAIL clear_ready: ready=%b count=%0d want 0/2", ifa.prod_ready_o, ifa.count_o); end
        step();
        clear = 1'b0;
        prod_valid = 1'b0;
        checks++;
        if (ifa.acc_o !== 20'd0 || ifb.acc_o !== 17'd0 || ifa.count_o !== 3'd0 || ifa.acc_valid_o !== 1'b0)
            begin failures++; $display("FAIL clear_mid_zero: acc_a=%0h acc_b=%0h count=%0d valid=%b want 0/0/0/0", ifa.acc_o, ifb.acc_o, ifa.count_o, ifa.acc_valid_o); end
        step();
        checks++;
        if (ifa.acc_o !== 20'd0 || ifa.count_o !== 3'd0)
            begin failures++; $display("FAIL clear_mid_settle: acc=%0h count=%0d want 0/0", ifa.acc_o, ifa.count_o); end
        beats[0] = 16'd5; beats[1] = 16'd6; beats[2] = 16'd7; beats[3] = 16'd8;
        feed_beats(0, 1);
        finish_result(1, 1'b0, 1'b0);
    endtask

    task automatic test_clear_in_done();
        for (int i = 0; i < 4; i++) beats[i] = 16'($urandom);
        feed_beats(0, 1);
        finish_result(2, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) beats[i] = 16'($urandom);
        feed_beats(0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ifa.acc_o !== 20'd0 || ifb.acc_o !== 17'd0 || ifa.acc_valid_o !== 1'b0 ||
            ifa.sat_o !== 1'b0 || ifa.count_o !== 3'd0 || ifa.prod_ready_o !== 1'b1)
            begin failures++; $display("FAIL async_reset: acc=%0h valid=%b sat=%b count=%0d ready=%b want 0/0/0/0/1", ifa.acc_o, ifa.acc_valid_o, ifa.sat_o, ifa.count_o, ifa.prod_ready_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) beats[i] = 16'd7;
        feed_beats(0, 0);
        finish_result(0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++)
                beats[i] = ($urandom_range(2, 0) == 0) ? 16'hFFFF - 16'($urandom_range(15, 0)) : 16'($urandom);
            feed_beats(0, 3);
            finish_result(int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)), ($urandom_range(4, 0) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_backpressure();
        test_saturation();
        test_clear_mid();
        test_clear_in_done();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
